wrr_scheduler: RTL and testbench
================================

WRR_SCHEDULER -- requirements
Module: wrr_scheduler

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 wrr_en  in  1  1 = weighted round robin, 0 = strict priority; one bit of the top-level wrr_enable per output port.
REQ-004 q_nonempty  in  8  bit q set = priority queue q of this output port holds at least one packet.
REQ-005 pause  in  1  1 = issue no new grant.
REQ-006 grant_ready  in  1  read path accepts the grant this cycle.
REQ-007 pkt_eop  in  1  read path finished the packet of the current grant.
REQ-008 grant_vld  out  1  grant offered.
REQ-009 grant_prior  out  3  queue being granted; stable while grant_vld is high.
REQ-010 busy  out  1  high from accepted grant until pkt_eop.

Function
REQ-011 Priority order SHALL be queue 7 highest, queue 0 lowest.
REQ-012 Each queue q SHALL have a 4-bit credit counter with weight q+1 (queue 7 = 8, queue 0 = 1; 36 per round).
REQ-013 The FSM SHALL have states IDLE, GRANT and BUSY.
REQ-014 IDLE: if pause=0 and q_nonempty!=0, register the selection into grant_prior and go to GRANT, so grant_vld rises 1 cycle after the request is seen.
REQ-015 IDLE with pause=1 or q_nonempty=0: remain in IDLE; grant_vld=0.
REQ-016 Strict mode: select the highest-index set bit of q_nonempty; credits are not modified.
REQ-017 WRR mode, eligible = q_nonempty AND credit>0: select the highest eligible queue.
REQ-018 WRR mode, q_nonempty!=0 but eligible=0: reload every credit to its weight in the same cycle and select the highest nonempty queue, treating credits as freshly reloaded.
REQ-019 GRANT: hold grant_vld=1 and grant_prior stable until grant_ready=1. The grant is never retracted, even if q_nonempty or pause changes.
REQ-020 GRANT with grant_vld and grant_ready both high: decrement the granted queue's credit (WRR only) and go to BUSY; grant_vld=0 and busy=1 from the next cycle.
REQ-021 A reload (REQ-018) and a decrement in the same cycle SHALL resolve to weight-1 for the decremented queue.
REQ-022 BUSY: wait for pkt_eop=1, then go to IDLE; busy=0 the next cycle.
REQ-023 pkt_eop SHALL be ignored outside BUSY.
REQ-024 Back-to-back minimum: pkt_eop in cycle M gives the earliest next grant_vld in cycle M+2.
REQ-025 While wrr_en=0, all credits SHALL be held at their weights, so WRR resumes from a full round.
REQ-026 Credits SHALL never underflow; a decrement at 0 is impossible by construction and is asserted against.

Reset
REQ-027 On rst_n low: state=IDLE, grant_vld=0, grant_prior=0, busy=0, credit[q]=q+1, immediately and asynchronously.
REQ-028 Reset asserted mid-GRANT or mid-BUSY SHALL abandon the grant; after release, scheduling restarts from a full round.

Structure
REQ-029 Shared package hydra_pkg SHALL hold: NUM_PRIOR=8, PRIOR_W=3, CREDIT_W=4, the state enum {IDLE, GRANT, BUSY}, and the weight function (q+1).
REQ-030 Sub-module prior_sel SHALL be an 8-bit highest-set-bit encoder (index plus found flag), instantiated twice: once on eligible, once on q_nonempty.

Verification
REQ-031 Reset: after rst_n deasserts, grant_vld=0, busy=0, credits={8,7,6,5,4,3,2,1} for queues 7..0.
REQ-032 Strict: wrr_en=0, q_nonempty=8'h14, grant_ready=1, pkt_eop 2 cycles after each accept -> every grant has grant_prior=4; credits unchanged.
REQ-033 WRR: wrr_en=1, q_nonempty=8'h81 held, same handshake -> grant sequence 7,7,7,7,7,7,7,7,0, then repeats after reload.
REQ-034 Pause: q_nonempty=8'h02 with pause=1 for 5 cycles -> no grant_vld; pause drops in cycle N -> grant_vld=1 with grant_prior=1 in N+1.
REQ-035 Stall: grant_ready=0 for 4 cycles while q_nonempty drops to 0 -> grant_vld and grant_prior held steady; accepted on the first cycle grant_ready=1.
REQ-036 Reset mid-BUSY: rst_n pulsed low while busy=1 -> busy=0 and credits at full weights; next grant follows REQ-014 timing.

Source files
------------

// File: rtl/hydra_pkg.sv
// Shared scheduler types, widths and the per-queue weight.
// Imported by every block of the output-port scheduler slice.
package hydra_pkg;

   localparam int NUM_PRIOR = 8;
   localparam int PRIOR_W   = 3;
   localparam int CREDIT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY
   } state_t;

   function automatic logic [CREDIT_W-1:0] weight(
      input logic [PRIOR_W-1:0] q
   );
      return {1'b0, q} + 4'd1;
   endfunction

endpackage

// File: rtl/prior_sel.sv
// Highest-set-bit encoder over the priority queues.
// Queue 7 wins over queue 0.
module prior_sel
   import hydra_pkg::*;
(
   input  logic [NUM_PRIOR-1:0] req,
   output logic [PRIOR_W-1:0]   idx,
   output logic                 found
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_PRIOR; i++) begin
         if (req[i]) idx = PRIOR_W'(i);
      end
      found = |req;
   end

endmodule

// File: rtl/wrr_scheduler.sv
// Per-output-port scheduler: strict priority or weighted round robin.
// IDLE -> GRANT (valid/ready) -> BUSY (until end of packet).
module wrr_scheduler
   import hydra_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wrr_en,
   input  logic [NUM_PRIOR-1:0] q_nonempty,
   input  logic                 pause,
   input  logic                 grant_ready,
   input  logic                 pkt_eop,
   output logic                 grant_vld,
   output logic [PRIOR_W-1:0]   grant_prior,
   output logic                 busy
);

   state_t state, state_nx;

   logic [CREDIT_W-1:0] credit    [NUM_PRIOR];
   logic [CREDIT_W-1:0] credit_nx [NUM_PRIOR];

   logic [NUM_PRIOR-1:0] eligible;
   logic [PRIOR_W-1:0]   el_idx, ne_idx, sel;
   logic                 el_found, ne_found;
   logic                 reload, dec;

   always_comb begin
      for (int i = 0; i < NUM_PRIOR; i++) begin
         eligible[i] = q_nonempty[i] && (credit[i] != '0);
      end
   end

   prior_sel u_sel_el (
      .req   (eligible),
      .idx   (el_idx),
      .found (el_found)
   );

   prior_sel u_sel_ne (
      .req   (q_nonempty),
      .idx   (ne_idx),
      .found (ne_found)
   );

   // An exhausted round falls back to the nonempty encoder and reloads.
   assign sel = (wrr_en && el_found) ? el_idx : ne_idx;

   always_comb begin
      state_nx = state;
      reload   = 1'b0;
      dec      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!pause && ne_found) begin
               state_nx = GRANT;
               reload   = wrr_en && !el_found;
            end
         end
         GRANT: begin
            if (grant_ready) begin
               state_nx = BUSY;
               dec      = wrr_en;
            end
         end
         BUSY: begin
            if (pkt_eop) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_PRIOR; i++) begin
         credit_nx[i] = credit[i];
         if (!wrr_en || reload) credit_nx[i] = weight(PRIOR_W'(i));
         if (dec && grant_prior == PRIOR_W'(i)) begin
            credit_nx[i] = credit_nx[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant_prior <= '0;
         for (int i = 0; i < NUM_PRIOR; i++) begin
            credit[i] <= weight(PRIOR_W'(i));
         end
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx == GRANT) grant_prior <= sel;
         for (int i = 0; i < NUM_PRIOR; i++) begin
            credit[i] <= credit_nx[i];
         end
      end
   end

   assign grant_vld = (state == GRANT);
   assign busy      = (state == BUSY);

   a_no_underflow: assert property (
      @(posedge clk) disable iff (!rst_n)
      dec |-> (credit[grant_prior] != '0)
   );

endmodule

// File: tb/tb_wrr_scheduler.sv
// Directed bench for wrr_scheduler.
// Scenario tasks with inline expected values.
module tb_wrr_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wrr_en;
   logic [7:0] q_nonempty;
   logic       pause;
   logic       grant_ready;
   logic       pkt_eop;
   logic       grant_vld;
   logic [2:0] grant_prior;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wrr_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wrr_en      (wrr_en),
      .q_nonempty  (q_nonempty),
      .pause       (pause),
      .grant_ready (grant_ready),
      .pkt_eop     (pkt_eop),
      .grant_vld   (grant_vld),
      .grant_prior (grant_prior),
      .busy        (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for a grant, lets it be accepted, ends the packet 2 cycles on.
   task automatic do_grant(output logic [2:0] p, output bit ok);
      ok = 1'b0;
      p  = 3'd0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (grant_vld) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         p = grant_prior;
         step();
         step();
         pkt_eop = 1'b1;
         step();
         pkt_eop = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_c;
      rst_n = 1'b1;
      wrr_en = 1'b0;
      q_nonempty = 8'h00;
      pause = 1'b0;
      grant_ready = 1'b0;
      pkt_eop = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (grant_vld !== 1'b0 || busy !== 1'b0 || grant_prior !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_async vld=%b busy=%b prior=%0d want 0 0 0",
                  grant_vld, busy, grant_prior);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      vectors++;
      if (grant_vld !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out vld=%b busy=%b want 0 0",
                  grant_vld, busy);
      end
      for (int q = 0; q < 8; q++) begin
         exp_c = 4'(q + 1);
         vectors++;
         if (dut.credit[q] !== exp_c) begin
            miscompares++;
            $display("FAIL reset_credit q%0d got %0d want %0d",
                     q, dut.credit[q], exp_c);
         end
      end
   endtask

   task automatic test_strict();
      logic [2:0] p;
      bit ok;
      logic [3:0] exp_c;
      wrr_en = 1'b0;
      q_nonempty = 8'h14;
      grant_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         do_grant(p, ok);
         vectors++;
         if (!ok || p !== 3'd4) begin
            miscompares++;
            $display("FAIL strict_grant%0d ok=%0b prior=%0d want 4",
                     n, ok, p);
         end
      end
      for (int q = 0; q < 8; q++) begin
         exp_c = 4'(q + 1);
         vectors++;
         if (dut.credit[q] !== exp_c) begin
            miscompares++;
            $display("FAIL strict_credit q%0d got %0d want %0d",
                     q, dut.credit[q], exp_c);
         end
      end
   endtask

   task automatic test_wrr();
      logic [2:0] p;
      logic [2:0] exp_p;
      bit ok;
      wrr_en = 1'b1;
      q_nonempty = 8'h81;
      grant_ready = 1'b1;
      for (int n = 0; n < 18; n++) begin
         exp_p = ((n % 9) == 8) ? 3'd0 : 3'd7;
         do_grant(p, ok);
         vectors++;
         if (!ok || p !== exp_p) begin
            miscompares++;
            $display("FAIL wrr_seq%0d ok=%0b prior=%0d want %0d",
                     n, ok, p, exp_p);
         end
      end
      vectors++;
      if (dut.credit[7] !== 4'd0 || dut.credit[0] !== 4'd0) begin
         miscompares++;
         $display("FAIL wrr_credit c7=%0d c0=%0d want 0 0",
                  dut.credit[7], dut.credit[0]);
      end
   endtask

   task automatic test_pause_stall();
      wrr_en = 1'b0;
      grant_ready = 1'b0;
      pause = 1'b1;
      q_nonempty = 8'h02;
      for (int n = 0; n < 5; n++) begin
         step();
         vectors++;
         if (grant_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_hold%0d vld=%b want 0", n, grant_vld);
         end
      end
      pause = 1'b0;
      step();
      vectors++;
      if (grant_vld !== 1'b1 || grant_prior !== 3'd1) begin
         miscompares++;
         $display("FAIL pause_release vld=%b prior=%0d want 1 1",
                  grant_vld, grant_prior);
      end
      q_nonempty = 8'h00;
      pause = 1'b1;
      for (int n = 0; n < 4; n++) begin
         step();
         vectors++;
         if (grant_vld !== 1'b1 || grant_prior !== 3'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d vld=%b prior=%0d busy=%b want 1 1 0",
                     n, grant_vld, grant_prior, busy);
         end
      end
      grant_ready = 1'b1;
      step();
      grant_ready = 1'b0;
      vectors++;
      if (grant_vld !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_accept vld=%b busy=%b want 0 1",
                  grant_vld, busy);
      end
      step();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_hold busy=%b want 1", busy);
      end
      pkt_eop = 1'b1;
      step();
      pkt_eop = 1'b0;
      pause = 1'b0;
      vectors++;
      if (busy !== 1'b0 || grant_vld !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_eop busy=%b vld=%b want 0 0", busy, grant_vld);
      end
   endtask

   task automatic test_back_to_back();
      wrr_en = 1'b0;
      q_nonempty = 8'h01;
      grant_ready = 1'b1;
      pkt_eop = 1'b1;
      step();
      pkt_eop = 1'b0;
      vectors++;
      if (grant_vld !== 1'b1 || grant_prior !== 3'd0) begin
         miscompares++;
         $display("FAIL b2b_first vld=%b prior=%0d want 1 0 (eop outside busy)",
                  grant_vld, grant_prior);
      end
      step();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_busy busy=%b want 1", busy);
      end
      pkt_eop = 1'b1;
      step();
      pkt_eop = 1'b0;
      vectors++;
      if (busy !== 1'b0 || grant_vld !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_gap busy=%b vld=%b want 0 0", busy, grant_vld);
      end
      grant_ready = 1'b0;
      step();
      vectors++;
      if (grant_vld !== 1'b1 || grant_prior !== 3'd0) begin
         miscompares++;
         $display("FAIL b2b_next vld=%b prior=%0d want 1 0",
                  grant_vld, grant_prior);
      end
      grant_ready = 1'b1;
      step();
      pkt_eop = 1'b1;
      step();
      pkt_eop = 1'b0;
      q_nonempty = 8'h00;
   endtask

   task automatic test_reset_busy();
      logic [3:0] exp_c;
      wrr_en = 1'b1;
      q_nonempty = 8'h81;
      grant_ready = 1'b1;
      step();
      step();
      step();
      vectors++;
      if (busy !== 1'b1 || dut.credit[7] !== 4'd7) begin
         miscompares++;
         $display("FAIL rstb_setup busy=%b c7=%0d want 1 7",
                  busy, dut.credit[7]);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || grant_vld !== 1'b0) begin
         miscompares++;
         $display("FAIL rstb_async busy=%b vld=%b want 0 0", busy, grant_vld);
      end
      for (int q = 0; q < 8; q++) begin
         exp_c = 4'(q + 1);
         vectors++;
         if (dut.credit[q] !== exp_c) begin
            miscompares++;
            $display("FAIL rstb_credit q%0d got %0d want %0d",
                     q, dut.credit[q], exp_c);
         end
      end
      step();
      rst_n = 1'b1;
      #1;
      vectors++;
      if (grant_vld !== 1'b0) begin
         miscompares++;
         $display("FAIL rstb_release vld=%b want 0", grant_vld);
      end
      step();
      vectors++;
      if (grant_vld !== 1'b1 || grant_prior !== 3'd7) begin
         miscompares++;
         $display("FAIL rstb_regrant vld=%b prior=%0d want 1 7",
                  grant_vld, grant_prior);
      end
   endtask

   initial begin
      test_reset();
      test_strict();
      test_wrr();
      test_pause_stall();
      test_back_to_back();
      test_reset_busy();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
